vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates the pixel-coordinate and sync stream that all text and graphics overlay blocks consume: pixel_x, pixel_y, video_on and the per-pixel tick.
- Drives the VGA connector's hsync and vsync.
- Sits at the top of the video pipeline, one instance per display, fed by the 100 MHz system clock.
- Its counters are the single timing source for every overlay stage downstream.

Parameters:
- TICK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); legal values are 2 to 16.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_DELAY, 2, clock cycles of sync/video_on delay; used only when VGA_SYNC_DELAY_EN is defined.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- p_tick  out  1  one-clk pulse marking each pixel period.
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1.
- video_on  out  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- line_start  out  1  one-clk pulse on the p_tick where pixel_x wraps to 0.
- frame_start  out  1  one-clk pulse on the p_tick where pixel_x and pixel_y both wrap to 0.

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = the analogous vertical sum (525).
- Reset values (async on rst_n low): tick counter 0, p_tick 0, pixel_x 0, pixel_y 0, hsync 1, vsync 1, line_start 0, frame_start 0. video_on therefore reads 1 at position (0,0) once rst_n is high.
- Tick counter:
  - Counts 0..TICK_DIV-1 every clk and wraps.
  - p_tick is registered and high exactly in the clk after the counter reaches TICK_DIV-1.
  - Result: period TICK_DIV clks, duty 1 clk.
  - First p_tick is TICK_DIV clks after reset release.
- Horizontal counter:
  - Advances only on a clk where p_tick=1.
  - Goes from H_TOTAL-1 to 0; otherwise +1.
- Vertical counter:
  - Advances only when p_tick=1 and pixel_x=H_TOTAL-1.
  - Goes from V_TOTAL-1 to 0; otherwise +1.
- Outputs change only on p_tick clks; between ticks every output is held.
- hsync and vsync are registered from the next-state counter values, so they are exactly aligned with the pixel_x/pixel_y they describe (zero skew).
  - hsync=0 iff H_DISPLAY+H_FRONT <= pixel_x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync=0 iff V_DISPLAY+V_FRONT <= pixel_y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- video_on is combinational from the registered counters; no glitch-free requirement beyond that.
- line_start and frame_start are registered and assert in the same clk that pixel_x becomes 0; each lasts 1 clk.
- Reset mid-line: all state returns to reset values immediately. After release, the frame restarts from (0,0) with no partial sync pulse.
- No input handshakes; the block free-runs after reset.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- When defined:
  - hsync, vsync and video_on each pass through a SYNC_DELAY-clk shift register (reset value 1, 1, 0).
  - This matches the synchronous font ROM and rgb output register latency of downstream overlays.
  - pixel_x, pixel_y, p_tick, line_start and frame_start are NOT delayed.
- When undefined: no delay registers exist; timing is exactly as in Behaviour.

Test Plan:
1. Reset: hold rst_n=0 for 10 clks, release -> all outputs at reset values. First p_tick at clk 4 after release; pixel_x=1 after first tick.
2. Line timing: run 800 ticks -> pixel_x goes 0..799 then 0. line_start pulses once at the wrap and pixel_y increments by 1. hsync low for exactly 96 ticks starting at pixel_x=656.
3. Frame timing: run 800*525 ticks -> frame_start pulses once. vsync low exactly while pixel_y=490 and 491. video_on high for exactly 640*480 ticks per frame.
4. Tick holding: sample outputs at every clk between p_ticks -> pixel_x/pixel_y/hsync/vsync unchanged across the 3 non-tick clks.
5. Mid-frame reset: assert rst_n at pixel_x=700, pixel_y=300 -> same clk async clear to 0/0 with hsync=vsync=1. Resumes from 0 after release.
6. VGA_SYNC_DELAY_EN with SYNC_DELAY=2: hsync falls exactly 2 clks after pixel_x becomes 656; pixel_x is undelayed. video_on falls 2 clks after pixel_x becomes 640.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Pixel-tick, raster counters and VGA sync generation for the
//             overlay pipeline. Optional sync/video_on delay line is enabled
//             by defining VGA_SYNC_DELAY_EN.
//  Revision : 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int TICK_DIV   = 4,
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int              c_tick_w    = $clog2(TICK_DIV);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);

    localparam logic [9:0] c_h_last   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] c_v_last   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] c_h_disp   = 10'(H_DISPLAY);
    localparam logic [9:0] c_v_disp   = 10'(V_DISPLAY);
    localparam logic [9:0] c_hs_first = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_hs_last  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_vs_first = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_vs_last  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [c_tick_w-1:0] r_tick_cnt;
    logic                r_p_tick;
    logic [9:0]          r_pixel_x;
    logic [9:0]          r_pixel_y;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_line_start;
    logic                r_frame_start;

    logic                w_x_wrap;
    logic                w_y_wrap;
    logic [9:0]          w_x_next;
    logic [9:0]          w_y_next;
    logic                w_hsync_next;
    logic                w_vsync_next;
    logic                w_video_on;

    always_comb begin
        w_x_wrap = (r_pixel_x == c_h_last);
        w_y_wrap = w_x_wrap && (r_pixel_y == c_v_last);
        w_x_next = w_x_wrap ? 10'd0 : r_pixel_x + 10'd1;
        if (w_y_wrap) begin
            w_y_next = 10'd0;
        end else if (w_x_wrap) begin
            w_y_next = r_pixel_y + 10'd1;
        end else begin
            w_y_next = r_pixel_y;
        end
        // Syncs decode the next position so they land with the counters they describe.
        w_hsync_next = !((w_x_next >= c_hs_first) && (w_x_next <= c_hs_last));
        w_vsync_next = !((w_y_next >= c_vs_first) && (w_y_next <= c_vs_last));
        w_video_on   = (r_pixel_x < c_h_disp) && (r_pixel_y < c_v_disp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_p_tick   <= 1'b0;
        end else begin
            r_tick_cnt <= (r_tick_cnt == c_tick_last) ? '0 : r_tick_cnt + 1'b1;
            r_p_tick   <= (r_tick_cnt == c_tick_last);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel_x     <= 10'd0;
            r_pixel_y     <= 10'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (r_p_tick) begin
                r_pixel_x     <= w_x_next;
                r_pixel_y     <= w_y_next;
                r_hsync       <= w_hsync_next;
                r_vsync       <= w_vsync_next;
                r_line_start  <= w_x_wrap;
                r_frame_start <= w_y_wrap;
            end
        end
    end

    assign p_tick      = r_p_tick;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_SYNC_DELAY_EN
    generate
        if (SYNC_DELAY > 0) begin : g_sync_delay
            logic [SYNC_DELAY-1:0] r_hsync_dly;
            logic [SYNC_DELAY-1:0] r_vsync_dly;
            logic [SYNC_DELAY-1:0] r_video_dly;

            // Matches the font ROM + rgb register latency of the overlay stages.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hsync_dly <= '1;
                    r_vsync_dly <= '1;
                    r_video_dly <= '0;
                end else begin
                    r_hsync_dly[0] <= r_hsync;
                    r_vsync_dly[0] <= r_vsync;
                    r_video_dly[0] <= w_video_on;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        r_hsync_dly[i] <= r_hsync_dly[i-1];
                        r_vsync_dly[i] <= r_vsync_dly[i-1];
                        r_video_dly[i] <= r_video_dly[i-1];
                    end
                end
            end

            assign hsync    = r_hsync_dly[SYNC_DELAY-1];
            assign vsync    = r_vsync_dly[SYNC_DELAY-1];
            assign video_on = r_video_dly[SYNC_DELAY-1];
        end else begin : g_sync_nodelay
            assign hsync    = r_hsync;
            assign vsync    = r_vsync;
            assign video_on = w_video_on;
        end
    endgenerate
`else
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = w_video_on;
`endif

endmodule
`default_nettype wire
